// File: rtl/mvm_systolic_engine_if.sv
// ---------------------------------------------------------------------------
// mvm_systolic_engine_if
//   Byte-write load port of the systolic matrix-vector engine. The data
//   fetcher (master) presents one element per cycle together with the FIFO
//   it targets. The engine (slave) answers with a combinational ready.
//
//   Signals:
//     in_data  : element to write (DATA_WIDTH bits)
//     in_sel   : target FIFO, 0..ROWS-1 = row of A, ROWS = vector B
//     in_valid : write request from the master
//     in_ready : write accepted when in_valid && in_ready at posedge
// ---------------------------------------------------------------------------
interface mvm_systolic_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int SEL_W      = $clog2(ROWS + 1)
);

  logic [DATA_WIDTH-1:0] in_data;
  logic [SEL_W-1:0]      in_sel;
  logic                  in_valid;
  logic                  in_ready;

  modport master (
    output in_data,
    output in_sel,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_sel,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/mvm_systolic_engine.sv
// ---------------------------------------------------------------------------
// mvm_systolic_engine
//   Computes C = A * B for a ROWS x COLS matrix A and a COLS-element vector B.
//   A (one FIFO per row) and B (one extra FIFO) are loaded through the
//   in_bus write port. A run pops B once per cycle into a skewed delay chain
//   so that row i sees B[j] exactly when it pops A[i][j]; each row owns one
//   MAC accumulator. Supports signed operands, accumulate-into-result,
//   B retention across runs, start-error detection and a FIFO flush.
//
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     in_bus       : element write port (slave side)
//     start        : run request, sampled every posedge in LOAD
//     signed_mode  : two's-complement operands (latched at accepted start)
//     accumulate   : seed MACs from the current result (latched)
//     keep_b       : recirculate B words into the B FIFO (latched)
//     clear        : synchronous flush of every FIFO, LOAD only
//     busy         : high while the array is executing
//     done         : one-cycle pulse, result just updated
//     start_err    : one-cycle pulse, start rejected because a FIFO was short
//     result       : per-row results, stable until the next done or reset
// ---------------------------------------------------------------------------
module mvm_systolic_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int SEL_W      = $clog2(ROWS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mvm_systolic_engine_if.slave in_bus,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic                 accumulate,
  input  logic                 keep_b,
  input  logic                 clear,
  output logic                 busy,
  output logic                 done,
  output logic                 start_err,
  output logic [ACC_WIDTH-1:0] result [0:ROWS-1]
);

  localparam int PTR_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = $clog2(COLS + 1);
  localparam int K_W   = $clog2(ROWS + COLS);
  localparam int DLY_N = (ROWS > 1) ? ROWS - 1 : 1;

  localparam logic [SEL_W-1:0] B_SEL    = SEL_W'(ROWS);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(COLS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(COLS - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(ROWS + COLS - 2);
  localparam logic [K_W-1:0]   K_B_END  = K_W'(COLS);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_EXEC,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  // FIFO index ROWS is the B vector, 0..ROWS-1 are the rows of A.
  logic [DATA_WIDTH-1:0] mem_q    [0:ROWS][0:COLS-1];
  logic [DATA_WIDTH-1:0] mem_d    [0:ROWS][0:COLS-1];
  logic [PTR_W-1:0]      rd_ptr_q [0:ROWS];
  logic [PTR_W-1:0]      rd_ptr_d [0:ROWS];
  logic [PTR_W-1:0]      wr_ptr_q [0:ROWS];
  logic [PTR_W-1:0]      wr_ptr_d [0:ROWS];
  logic [CNT_W-1:0]      cnt_q    [0:ROWS];
  logic [CNT_W-1:0]      cnt_d    [0:ROWS];

  logic [K_W-1:0]        exec_cnt_q, exec_cnt_d;
  logic                  sgn_q, sgn_d;
  logic                  acc_mode_q, acc_mode_d;
  logic                  keep_b_q, keep_b_d;

  logic [ACC_WIDTH-1:0]  acc_q    [0:ROWS-1];
  logic [ACC_WIDTH-1:0]  acc_d    [0:ROWS-1];
  logic [ACC_WIDTH-1:0]  result_q [0:ROWS-1];
  logic [ACC_WIDTH-1:0]  result_d [0:ROWS-1];
  logic [ACC_WIDTH-1:0]  acc_base;

  logic [DATA_WIDTH-1:0] b_dly_q  [0:DLY_N-1];
  logic [DATA_WIDTH-1:0] b_dly_d  [0:DLY_N-1];
  logic [DATA_WIDTH-1:0] b_head;
  logic [DATA_WIDTH-1:0] b_pipe   [0:ROWS-1];

  logic done_q, done_d;
  logic start_err_q, start_err_d;
  logic sel_ok, tgt_full, all_full, wr_fire;

  // Widen an operand to the accumulator width, sign- or zero-extending.
  function automatic logic [ACC_WIDTH-1:0] ext(input logic [DATA_WIDTH-1:0] x,
                                               input logic sgn);
    ext = {{(ACC_WIDTH - DATA_WIDTH){sgn & x[DATA_WIDTH-1]}}, x};
  endfunction

  // FIFO pointers wrap at COLS, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Out-of-range selects are treated as a full target so they are never ready.
  assign sel_ok          = (in_bus.in_sel <= B_SEL);
  assign tgt_full        = sel_ok ? (cnt_q[in_bus.in_sel] == FULL_CNT) : 1'b1;
  assign in_bus.in_ready = (state_q == ST_LOAD) && !tgt_full;
  assign wr_fire         = in_bus.in_valid && in_bus.in_ready;

  // Start is only legal when every FIFO holds a complete operand set,
  // judged on the counts before any same-cycle write.
  always_comb begin
    all_full = 1'b1;
    for (int f = 0; f <= ROWS; f++) begin
      if (cnt_q[f] != FULL_CNT) all_full = 1'b0;
    end
  end

  // Skew chain: row 0 consumes the B word popped this cycle, row i the word
  // popped i cycles earlier.
  always_comb begin
    b_head    = mem_q[ROWS][rd_ptr_q[ROWS]];
    b_pipe[0] = b_head;
    for (int i = 1; i < ROWS; i++) begin
      b_pipe[i] = b_dly_q[i-1];
    end
  end

  // Next-state logic: FIFO loading and flush in LOAD, the MAC sweep in EXEC,
  // and the result commit in DONE.
  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    exec_cnt_d  = exec_cnt_q;
    sgn_d       = sgn_q;
    acc_mode_d  = acc_mode_q;
    keep_b_d    = keep_b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    acc_base    = '0;
    done_d      = 1'b0;
    start_err_d = 1'b0;

    b_dly_d[0] = b_head;
    for (int i = 1; i < DLY_N; i++) begin
      b_dly_d[i] = b_dly_q[i-1];
    end

    case (state_q)
      ST_LOAD: begin
        if (clear) begin
          for (int f = 0; f <= ROWS; f++) begin
            rd_ptr_d[f] = '0;
            wr_ptr_d[f] = '0;
            cnt_d[f]    = '0;
          end
        end else begin
          if (start) begin
            if (all_full) begin
              sgn_d      = signed_mode;
              acc_mode_d = accumulate;
              keep_b_d   = keep_b;
              exec_cnt_d = '0;
              state_d    = ST_EXEC;
            end else begin
              start_err_d = 1'b1;
            end
          end
          if (wr_fire) begin
            mem_d[in_bus.in_sel][wr_ptr_q[in_bus.in_sel]] = in_bus.in_data;
            wr_ptr_d[in_bus.in_sel] = next_ptr(wr_ptr_q[in_bus.in_sel]);
            cnt_d[in_bus.in_sel]    = cnt_q[in_bus.in_sel] + 1'b1;
          end
        end
      end

      ST_EXEC: begin
        // B is popped for the first COLS cycles; with keep_b the word goes
        // straight back in so the FIFO stays full in original order.
        if (exec_cnt_q < K_B_END) begin
          rd_ptr_d[ROWS] = next_ptr(rd_ptr_q[ROWS]);
          if (keep_b_q) begin
            mem_d[ROWS][wr_ptr_q[ROWS]] = b_head;
            wr_ptr_d[ROWS] = next_ptr(wr_ptr_q[ROWS]);
          end else begin
            cnt_d[ROWS] = cnt_q[ROWS] - 1'b1;
          end
        end
        // The seed is applied on the first sweep cycle so it uses the
        // latched accumulate bit.
        for (int i = 0; i < ROWS; i++) begin
          acc_base = (exec_cnt_q == '0) ? (acc_mode_q ? result_q[i] : '0) : acc_q[i];
          acc_d[i] = acc_base;
          if ((exec_cnt_q >= K_W'(i)) && (exec_cnt_q < K_W'(i + COLS))) begin
            acc_d[i]    = acc_base + ext(mem_q[i][rd_ptr_q[i]], sgn_q) * ext(b_pipe[i], sgn_q);
            rd_ptr_d[i] = next_ptr(rd_ptr_q[i]);
            cnt_d[i]    = cnt_q[i] - 1'b1;
          end
        end
        if (exec_cnt_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          exec_cnt_d = exec_cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = ST_LOAD;
      end

      default: state_d = ST_LOAD;
    endcase
  end

  // Control, accumulator and result registers; reset aborts any run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      exec_cnt_q  <= '0;
      sgn_q       <= 1'b0;
      acc_mode_q  <= 1'b0;
      keep_b_q    <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      for (int f = 0; f <= ROWS; f++) begin
        rd_ptr_q[f] <= '0;
        wr_ptr_q[f] <= '0;
        cnt_q[f]    <= '0;
      end
      for (int i = 0; i < ROWS; i++) begin
        acc_q[i]    <= '0;
        result_q[i] <= '0;
      end
      for (int d = 0; d < DLY_N; d++) begin
        b_dly_q[d] <= '0;
      end
    end else begin
      state_q     <= state_d;
      exec_cnt_q  <= exec_cnt_d;
      sgn_q       <= sgn_d;
      acc_mode_q  <= acc_mode_d;
      keep_b_q    <= keep_b_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      b_dly_q     <= b_dly_d;
    end
  end

  // FIFO storage needs no reset: emptiness is tracked by the counters.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign busy      = (state_q == ST_EXEC);
  assign done      = done_q;
  assign start_err = start_err_q;
  assign result    = result_q;

endmodule

// File: tb/tb_mvm_systolic_engine.sv
// ---------------------------------------------------------------------------
// tb_mvm_systolic_engine
//   Directed bench for mvm_systolic_engine at default parameters. Expected
//   result vectors are queued when a run is launched; a monitor pops and
//   compares them whenever done pulses. Control-path behaviour (latency,
//   start_err, in_ready, clear, reset abort) is checked inline.
// ---------------------------------------------------------------------------
module tb_mvm_systolic_engine;

  localparam int DW    = 8;
  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int ACC_W = 24;
  localparam int SEL_W = $clog2(ROWS + 1);

  typedef logic [ROWS-1:0][ACC_W-1:0] res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start, signed_mode, accumulate, keep_b, clear;
  logic             busy, done, start_err;
  logic [ACC_W-1:0] result [0:ROWS-1];

  int   n_checks = 0;
  int   n_errors = 0;
  res_t exp_q[$];

  mvm_systolic_engine_if #(.DATA_WIDTH(DW), .ROWS(ROWS)) bus ();

  mvm_systolic_engine #(
    .DATA_WIDTH(DW),
    .ROWS      (ROWS),
    .COLS      (COLS),
    .ACC_WIDTH (ACC_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_bus     (bus),
    .start      (start),
    .signed_mode(signed_mode),
    .accumulate (accumulate),
    .keep_b     (keep_b),
    .clear      (clear),
    .busy       (busy),
    .done       (done),
    .start_err  (start_err),
    .result     (result)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard monitor: every done pulse must match the oldest queued vector.
  always @(negedge clk) begin
    res_t got;
    res_t want;
    if (done) begin
      for (int i = 0; i < ROWS; i++) got[i] = result[i];
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("[TB] FAIL unexpected_done: got result %h, required no done pulse", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_errors++;
          $display("[TB] FAIL result_vector: got %h, required %h", got, want);
        end
      end
    end
  end

  function automatic res_t linear(input int base, input int step);
    res_t r;
    for (int i = 0; i < ROWS; i++) r[i] = ACC_W'(base + step * i);
    return r;
  endfunction

  function automatic res_t flat(input logic [ACC_W-1:0] v);
    res_t r;
    for (int i = 0; i < ROWS; i++) r[i] = v;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // One write on the load port, valid held across a single posedge.
  task automatic applyStimulus(input int sel, input logic [DW-1:0] data);
    @(negedge clk);
    bus.in_sel   = SEL_W'(sel);
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // kind 0: A[i][j] = i+j+1; kind 1: every element 0xFF.
  task automatic loadA(input int kind);
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        applyStimulus(i, (kind == 0) ? DW'(i + j + 1) : 8'hFF);
  endtask

  // kind 0: B[j] = j+1; kind 1: every element 0x02.
  task automatic loadB(input int kind, input int n);
    for (int j = 0; j < n; j++)
      applyStimulus(ROWS, (kind == 0) ? DW'(j + 1) : 8'h02);
  endtask

  // Launch a run, queue its expected result, and check latency and widths.
  task automatic runEngine(input logic sgn, input logic acc, input logic kb,
                           input res_t want, input string name);
    int done_at  = -1;
    int busy_cnt = 0;
    exp_q.push_back(want);
    @(negedge clk);
    start       = 1'b1;
    signed_mode = sgn;
    accumulate  = acc;
    keep_b      = kb;
    for (int m = 0; m < 40; m++) begin
      @(negedge clk);
      if (m == 0) begin
        start       = 1'b0;
        signed_mode = 1'b0;
        accumulate  = 1'b0;
        keep_b      = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_at = m;
        break;
      end
    end
    checkOutput({name, "_done_latency"}, done_at, 16);
    checkOutput({name, "_busy_cycles"}, busy_cnt, 15);
    @(negedge clk);
    checkOutput({name, "_done_width"}, {31'd0, done}, 0);
  endtask

  // Issue a start that must be rejected.
  task automatic startExpectErr(input string name);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({name, "_start_err"}, {31'd0, start_err}, 1);
    checkOutput({name, "_busy"}, {31'd0, busy}, 0);
    @(negedge clk);
    checkOutput({name, "_start_err_width"}, {31'd0, start_err}, 0);
    checkOutput({name, "_still_idle"}, {31'd0, busy | done}, 0);
  endtask

  initial begin
    int done_seen;
    start        = 1'b0;
    signed_mode  = 1'b0;
    accumulate   = 1'b0;
    keep_b       = 1'b0;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sel   = '0;
    bus.in_data  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 0);
    checkOutput("reset_done", {31'd0, done}, 0);
    checkOutput("reset_start_err", {31'd0, start_err}, 0);
    checkOutput("reset_result0", {8'd0, result[0]}, 0);
    checkOutput("reset_result7", {8'd0, result[7]}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.in_sel = '0;
    #1 checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 1);

    // Unsigned run keeping B: result[i] = 36i + 204
    $display("[TB] unsigned run with keep_b");
    loadA(0);
    loadB(0, 8);
    runEngine(1'b0, 1'b0, 1'b1, linear(204, 36), "unsigned_keepb");

    // Reload A only and accumulate: doubles the previous result
    $display("[TB] accumulate run reusing B");
    loadA(0);
    runEngine(1'b0, 1'b1, 1'b0, linear(408, 72), "accumulate");

    // 0xFF x 0x02 signed (-16) then unsigned (4080) reusing B
    $display("[TB] signed and unsigned 0xFF x 0x02");
    loadA(1);
    loadB(1, 8);
    runEngine(1'b1, 1'b0, 1'b1, flat(24'hFFFFF0), "signed_ff");
    loadA(1);
    runEngine(1'b0, 1'b0, 1'b0, flat(24'h000FF0), "unsigned_ff");

    // Baseline, then stale partial fill and clear
    $display("[TB] clear flush");
    loadA(0);
    loadB(0, 8);
    runEngine(1'b0, 1'b0, 1'b0, linear(204, 36), "baseline");
    repeat (3) applyStimulus(0, 8'h55);
    repeat (2) applyStimulus(5, 8'h55);
    repeat (2) applyStimulus(ROWS, 8'h55);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("clear_result0", {8'd0, result[0]}, 204);
    checkOutput("clear_result7", {8'd0, result[7]}, 456);
    startExpectErr("after_clear");

    // B one short, then overfill and bad select
    $display("[TB] start rejection and in_ready limits");
    loadA(0);
    loadB(0, 7);
    startExpectErr("b_seven");
    applyStimulus(ROWS, 8'd8);
    @(negedge clk);
    bus.in_sel   = SEL_W'(ROWS);
    bus.in_data  = 8'hAA;
    bus.in_valid = 1'b1;
    #1 checkOutput("b_ninth_ready", {31'd0, bus.in_ready}, 0);
    bus.in_sel = SEL_W'(9);
    #1 checkOutput("sel9_ready", {31'd0, bus.in_ready}, 0);
    bus.in_sel = '0;
    #1 checkOutput("a_full_ready", {31'd0, bus.in_ready}, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    runEngine(1'b0, 1'b0, 1'b0, linear(204, 36), "after_clear_run");

    // Reset in the middle of EXEC at k = 5
    $display("[TB] reset abort");
    loadA(0);
    loadB(0, 8);
    @(negedge clk);
    start = 1'b1;
    for (int m = 0; m <= 5; m++) begin
      @(negedge clk);
      if (m == 0) start = 1'b0;
    end
    checkOutput("abort_busy_before", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 0);
    checkOutput("abort_done", {31'd0, done}, 0);
    checkOutput("abort_result0", {8'd0, result[0]}, 0);
    checkOutput("abort_result7", {8'd0, result[7]}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int m = 0; m < 20; m++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("abort_no_done", done_seen, 0);
    bus.in_sel = '0;
    #1 checkOutput("abort_ready_a0", {31'd0, bus.in_ready}, 1);
    bus.in_sel = SEL_W'(ROWS);
    #1 checkOutput("abort_ready_b", {31'd0, bus.in_ready}, 1);
    loadA(0);
    loadB(0, 8);
    runEngine(1'b0, 1'b1, 1'b0, linear(204, 36), "post_reset_accum");

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
